// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg
// Description : Shared constants for the gpio_edge_irq register slave:
//               decode window geometry, register byte offsets and the
//               window-hit helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

  // Only addr[11:0] is decoded; each bank owns a 64-byte window.
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned WIN_LSB = 6;

  typedef logic [WIN_LSB-1:0] reg_off_t;

  // Write-side offsets
  localparam reg_off_t DIR_CLR    = 6'h00;
  localparam reg_off_t DIR_SET    = 6'h04;
  localparam reg_off_t OD_CLR     = 6'h08;
  localparam reg_off_t OD_SET     = 6'h0C;
  localparam reg_off_t OUT_CLR    = 6'h10;
  localparam reg_off_t OUT_SET    = 6'h14;
  localparam reg_off_t RISE_EN    = 6'h18;
  localparam reg_off_t FALL_EN    = 6'h1C;

  // Read-side offsets (IRQ_STATUS is also the W1C write offset)
  localparam reg_off_t DATA_IN    = 6'h20;
  localparam reg_off_t IRQ_STATUS = 6'h24;
  localparam reg_off_t OUT_RD     = 6'h28;
  localparam reg_off_t DIR_RD     = 6'h2C;
  localparam reg_off_t OD_RD      = 6'h30;
  localparam reg_off_t RISE_RD    = 6'h34;
  localparam reg_off_t FALL_RD    = 6'h38;

  // Compares the window-select bits of an access against the bank address.
  function automatic logic win_hit(input logic [ADDR_W-1:WIN_LSB] addr_win,
                                   input logic [ADDR_W-1:WIN_LSB] bank_win);
    return addr_win == bank_win;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_in_sync.sv
`default_nettype none
// ============================================================================
// Module      : gpio_in_sync
// Description : Pin input synchroniser with edge detect. Two flops resolve
//               metastability; a third holds the previous synchronised value
//               so raw rising/falling edges can be formed.
// Ports       : clk, rst_n      - clock, synchronous active-low reset
//               pin_i           - resolved pin levels (asynchronous)
//               s2_o            - synchronised level (stage 2)
//               rise_raw_o      - stage 2 high, stage 3 low
//               fall_raw_o      - stage 2 low, stage 3 high
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_in_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] s2_o,
  output logic [WIDTH-1:0] rise_raw_o,
  output logic [WIDTH-1:0] fall_raw_o
);

  logic [WIDTH-1:0] s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= pin_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign s2_o       = s2_q;
  assign rise_raw_o =  s2_q & ~s3_q;
  assign fall_raw_o = ~s2_q &  s3_q;

endmodule
`default_nettype wire

// File: rtl/gpio_edge_irq.sv
`default_nettype none
// ============================================================================
// Module      : gpio_edge_irq
// Description : GPIO bank slave on the ic0 register bus. Per-pin direction,
//               open-drain and output registers (set/clear by address),
//               synchronised inputs, and edge-triggered sticky W1C status
//               that drives a level interrupt.
// Ports       : clk, rst_n                - clock, synchronous active-low reset
//               b1_data_io                - bidirectional pins
//               ic0_c_axi_mst_wr_valid    - write strobe (addr/data valid)
//               ic0_axi_mst_wr_addr/data  - write address / data
//               ic0_c_axi_mst_rd_valid    - read strobe
//               ic0_axi_mst_rd_addr       - read address
//               ic0_c_axi_slv_rd_ready_0  - read response valid (1 cycle)
//               ic0_axi_slv_rd_data_0     - read data, 0 when not valid
//               irq                       - OR of IRQ_STATUS
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_edge_irq
  import gpio_pkg::*;
#(
  parameter int unsigned GPIO_BW = 4,
  parameter logic [31:0] BASE    = 32'h0000_0440,
  parameter logic [31:0] OFFSET  = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  inout  wire  [GPIO_BW-1:0] b1_data_io,
  input  logic               ic0_c_axi_mst_wr_valid,
  input  logic               ic0_c_axi_mst_rd_valid,
  input  logic [31:0]        ic0_axi_mst_wr_addr,
  input  logic [31:0]        ic0_axi_mst_wr_data,
  input  logic [31:0]        ic0_axi_mst_rd_addr,
  output logic               ic0_c_axi_slv_rd_ready_0,
  output logic [31:0]        ic0_axi_slv_rd_data_0,
  output logic               irq
);

  localparam logic [31:0] C_BANK_ADDR = BASE + OFFSET;

  // Architectural registers
  logic [GPIO_BW-1:0] dir_q, dir_d;
  logic [GPIO_BW-1:0] od_q, od_d;
  logic [GPIO_BW-1:0] out_q, out_d;
  logic [GPIO_BW-1:0] rise_en_q, rise_en_d;
  logic [GPIO_BW-1:0] fall_en_q, fall_en_d;
  logic [GPIO_BW-1:0] status_q, status_d;

  // Write pipeline stage: captured in cycle N, applied at the end of N+1
  logic               wr_vld_q;
  reg_off_t           wr_off_q;
  logic [GPIO_BW-1:0] wr_data_q;

  // Read response
  logic               rd_ready_q, rd_ready_d;
  logic [31:0]        rd_data_q, rd_data_d;

  logic [GPIO_BW-1:0] w_pin_in;
  logic [GPIO_BW-1:0] w_s2, w_rise_raw, w_fall_raw;
  logic [GPIO_BW-1:0] w_w1c;
  logic               w_wr_hit, w_rd_hit;
  logic               w_unused;

  assign w_wr_hit = win_hit(ic0_axi_mst_wr_addr[ADDR_W-1:WIN_LSB],
                            C_BANK_ADDR[ADDR_W-1:WIN_LSB]);
  assign w_rd_hit = win_hit(ic0_axi_mst_rd_addr[ADDR_W-1:WIN_LSB],
                            C_BANK_ADDR[ADDR_W-1:WIN_LSB]);

  // Upper address bits sit outside the decoded window.
  assign w_unused = ^{ic0_axi_mst_wr_addr[31:ADDR_W],
                      ic0_axi_mst_rd_addr[31:ADDR_W],
                      ic0_axi_mst_wr_data};

  // Pin drive: open-drain pins only ever pull low; a high OUT floats them.
  for (genvar i = 0; i < GPIO_BW; i++) begin : g_pin
    assign b1_data_io[i] = (dir_q[i] && !(od_q[i] && out_q[i])) ? out_q[i] : 1'bz;
  end

  // Anything other than a clean 1 (0, X, Z) enters the synchroniser as 0.
  always_comb begin
    w_pin_in = '0;
    for (int i = 0; i < GPIO_BW; i++) begin
      if (b1_data_io[i] == 1'b1) begin
        w_pin_in[i] = 1'b1;
      end
    end
  end

  gpio_in_sync #(
    .WIDTH (GPIO_BW)
  ) u_in_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .pin_i      (w_pin_in),
    .s2_o       (w_s2),
    .rise_raw_o (w_rise_raw),
    .fall_raw_o (w_fall_raw)
  );

  // Register next-state from the pipelined write
  always_comb begin
    dir_d     = dir_q;
    od_d      = od_q;
    out_d     = out_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w_w1c     = '0;
    if (wr_vld_q) begin
      case (wr_off_q)
        DIR_CLR:    dir_d     = dir_q & ~wr_data_q;
        DIR_SET:    dir_d     = dir_q |  wr_data_q;
        OD_CLR:     od_d      = od_q  & ~wr_data_q;
        OD_SET:     od_d      = od_q  |  wr_data_q;
        OUT_CLR:    out_d     = out_q & ~wr_data_q;
        OUT_SET:    out_d     = out_q |  wr_data_q;
        RISE_EN:    rise_en_d = wr_data_q;
        FALL_EN:    fall_en_d = wr_data_q;
        IRQ_STATUS: w_w1c     = wr_data_q;
        default:    ;
      endcase
    end
    // A new edge in the same cycle as its W1C keeps the bit set.
    status_d = (status_q & ~w_w1c)
             | (w_rise_raw & rise_en_q)
             | (w_fall_raw & fall_en_q);
  end

  // Read response uses register values before this edge's updates.
  always_comb begin
    rd_ready_d = ic0_c_axi_mst_rd_valid && w_rd_hit;
    rd_data_d  = '0;
    if (rd_ready_d) begin
      case (reg_off_t'(ic0_axi_mst_rd_addr[WIN_LSB-1:0]))
        DATA_IN:    rd_data_d = 32'(w_s2);
        IRQ_STATUS: rd_data_d = 32'(status_q);
        OUT_RD:     rd_data_d = 32'(out_q);
        DIR_RD:     rd_data_d = 32'(dir_q);
        OD_RD:      rd_data_d = 32'(od_q);
        RISE_RD:    rd_data_d = 32'(rise_en_q);
        FALL_RD:    rd_data_d = 32'(fall_en_q);
        default:    rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dir_q      <= '0;
      od_q       <= '0;
      out_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      wr_vld_q   <= 1'b0;
      wr_off_q   <= '0;
      wr_data_q  <= '0;
      rd_ready_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      dir_q      <= dir_d;
      od_q       <= od_d;
      out_q      <= out_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      status_q   <= status_d;
      wr_vld_q   <= ic0_c_axi_mst_wr_valid && w_wr_hit;
      wr_off_q   <= reg_off_t'(ic0_axi_mst_wr_addr[WIN_LSB-1:0]);
      wr_data_q  <= ic0_axi_mst_wr_data[GPIO_BW-1:0];
      rd_ready_q <= rd_ready_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign ic0_c_axi_slv_rd_ready_0 = rd_ready_q;
  assign ic0_axi_slv_rd_data_0    = rd_data_q;
  assign irq                      = |status_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_edge_irq.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_edge_irq
// Description : Self-checking bench for gpio_edge_irq. Read expectations are
//               queued at issue time and matched by a monitor on rd_ready;
//               pin and irq levels are checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_edge_irq;

  localparam logic [31:0] C_BANK = 32'h0000_0440;

  logic        clk = 1'b0;
  logic        rst_n;
  wire  [3:0]  pins;
  logic        wr_valid, rd_valid;
  logic [31:0] wr_addr, wr_data, rd_addr;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        irq;

  logic [3:0]  tb_en, tb_val;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_resp = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  int          stamp_q[$];

  gpio_edge_irq #(
    .GPIO_BW (4),
    .BASE    (32'h0000_0440),
    .OFFSET  (32'h0000_0000)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .b1_data_io               (pins),
    .ic0_c_axi_mst_wr_valid   (wr_valid),
    .ic0_c_axi_mst_rd_valid   (rd_valid),
    .ic0_axi_mst_wr_addr      (wr_addr),
    .ic0_axi_mst_wr_data      (wr_data),
    .ic0_axi_mst_rd_addr      (rd_addr),
    .ic0_c_axi_slv_rd_ready_0 (rd_ready),
    .ic0_axi_slv_rd_data_0    (rd_data),
    .irq                      (irq)
  );

  // External pin drivers
  for (genvar i = 0; i < 4; i++) begin : g_drv
    assign pins[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] pins_hi();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (pins[i] === 1'b1);
    return r;
  endfunction

  task automatic idle();
    @(negedge clk);
    wr_valid = 1'b0;
    rd_valid = 1'b0;
  endtask

  task automatic idles(input int n);
    for (int k = 0; k < n; k++) idle();
  endtask

  task automatic wr(input logic [5:0] off, input logic [31:0] d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = C_BANK + 32'(off);
    wr_data  = d;
    rd_valid = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    rd_valid = 1'b1;
    rd_addr  = addr;
    wr_valid = 1'b0;
    exp_q.push_back(exp);
    stamp_q.push_back(cyc);
  endtask

  task automatic rd_miss(input logic [31:0] addr);
    @(negedge clk);
    rd_valid = 1'b1;
    rd_addr  = addr;
    wr_valid = 1'b0;
  endtask

  // Response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rd_ready === 1'b1) begin
        n_resp++;
        if (exp_q.size() == 0) begin
          chk("unexpected_rd_ready", 32'd1, 32'd0);
        end else begin
          logic [31:0] e;
          int          s;
          e = exp_q.pop_front();
          s = stamp_q.pop_front();
          chk("rd_data", rd_data, e);
          chk("rd_latency", 32'(cyc - s), 32'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr  = '0;
    tb_en    = '0;
    tb_val   = '0;
    idles(2);
    rst_n = 1'b1;
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_rd_ready", 32'(rd_ready), 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_pins", 32'(pins_hi()), 32'd0);

    // Output drive with write latency
    wr(6'h04, 32'hF);
    wr(6'h14, 32'h5);
    idle();
    chk("out_not_yet_n1", 32'(pins_hi()), 32'h0);
    idle();
    chk("out_pins_n2", 32'(pins_hi()), 32'h5);
    idles(2);
    rd(C_BANK + 32'h28, 32'h5);
    rd(C_BANK + 32'h2C, 32'hF);
    rd(C_BANK + 32'h20, 32'h5);
    idle();

    // Open-drain: OUT=1 floats, OUT=0 pulls low
    wr(6'h0C, 32'h3);
    wr(6'h10, 32'h4);
    wr(6'h00, 32'hC);
    idles(2);
    chk("od_pin0_float", 32'(pins_hi()), 32'h0);
    rd(C_BANK + 32'h30, 32'h3);
    rd(C_BANK + 32'h2C, 32'h3);
    rd(C_BANK + 32'h28, 32'h1);
    wr(6'h10, 32'h1);
    idles(2);
    rd(C_BANK + 32'h28, 32'h0);
    idle();

    // Rising edge on pin1, status at the 3rd edge, W1C clears
    wr(6'h18, 32'h2);
    wr(6'h00, 32'h2);
    idles(2);
    @(negedge clk);
    tb_en  = 4'b0010;
    tb_val = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    chk("irq_before_3rd_edge", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_at_3rd_edge", 32'(irq), 32'd1);
    rd(C_BANK + 32'h24, 32'h2);
    wr(6'h24, 32'h2);
    idle();
    chk("irq_w1c_n1", 32'(irq), 32'd1);
    idle();
    chk("irq_w1c_n2", 32'(irq), 32'd0);

    // Falling edge on pin0, then W1C colliding with a new fall
    wr(6'h1C, 32'h1);
    wr(6'h00, 32'h1);
    idle();
    @(negedge clk);
    tb_en  = 4'b0011;
    tb_val = 4'b0011;
    idles(4);
    @(negedge clk);
    tb_val = 4'b0010;
    idles(4);
    chk("irq_fall_pin0", 32'(irq), 32'd1);
    rd(C_BANK + 32'h24, 32'h1);
    idle();
    @(negedge clk);
    tb_val = 4'b0000;
    idles(4);
    @(negedge clk);
    tb_val = 4'b0010;
    idles(4);
    rd(C_BANK + 32'h24, 32'h3);
    idle();
    @(negedge clk);
    tb_val = 4'b0011;
    idles(4);
    @(negedge clk);
    tb_val = 4'b0010;
    wr(6'h24, 32'h3);
    idle();
    idle();
    chk("set_wins_irq", 32'(irq), 32'd1);
    rd(C_BANK + 32'h24, 32'h1);
    wr(6'h24, 32'h1);
    idles(2);
    chk("irq_cleared_bit0", 32'(irq), 32'd0);

    // Unmapped in-window offset answers 0; out-of-window gets no response
    rd(C_BANK + 32'h3C, 32'h0);
    idles(2);
    r0 = n_resp;
    rd_miss(C_BANK + 32'h40);
    idles(3);
    chk("miss_no_response", 32'(n_resp), 32'(r0));

    // Self-driven pin2 rising edge
    wr(6'h18, 32'h6);
    wr(6'h04, 32'h4);
    wr(6'h14, 32'h4);
    idles(6);
    chk("self_toggle_irq", 32'(irq), 32'd1);
    rd(C_BANK + 32'h24, 32'h4);
    rd(C_BANK + 32'h20, 32'h6);
    wr(6'h24, 32'h4);
    idles(3);
    chk("self_toggle_cleared", 32'(irq), 32'd0);

    // Reset one cycle after an OUT set: pending write is dropped
    @(negedge clk);
    tb_en = 4'b0000;
    idles(5);
    wr(6'h14, 32'h8);
    @(negedge clk);
    wr_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_write_irq", 32'(irq), 32'd0);
    chk("rst_mid_write_pins", 32'(pins_hi()), 32'h0);
    rd(C_BANK + 32'h28, 32'h0);
    rd(C_BANK + 32'h2C, 32'h0);
    idles(3);
    chk("rst_pins_later", 32'(pins_hi()), 32'h0);
    chk("pending_reads", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpio_edge_irq.md
Name: gpio_edge_irq

Overview:
Parametrised GPIO slave on the ic0 AXI-style register bus. GPIO_BW pins, each with direction, open-drain and output controls set and cleared by address. Inputs pass through a 2-flop synchroniser. Per-pin rising/falling edge detection sets sticky write-1-to-clear status bits that drive a level interrupt. One instance per GPIO bank, decoded by BASE+OFFSET within a 4 KB window.

Parameters:
GPIO_BW, 4, number of pins (1..32)
BASE, 32'h00000440, bank base address; BASE+OFFSET must be 64-byte aligned
OFFSET, 32'h00000000, instance offset (multiples of 32'h40)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous reset, active-low
b1_data_io  inout  GPIO_BW  pins
ic0_c_axi_mst_wr_valid  input  1  write strobe, address and data valid this cycle
ic0_c_axi_mst_rd_valid  input  1  read strobe
ic0_axi_mst_wr_addr  input  32  write address; bits [11:0] decoded
ic0_axi_mst_wr_data  input  32  write data; bits [GPIO_BW-1:0] used
ic0_axi_mst_rd_addr  input  32  read address; bits [11:0] decoded
ic0_c_axi_slv_rd_ready_0  output  1  read response valid, 1-cycle pulse
ic0_axi_slv_rd_data_0  output  32  read data, zero-extended; 0 when ready low
irq  output  1  level interrupt: OR of IRQ_STATUS

Behaviour:
- Reset: one clock with rst_n=0 zeroes OUT, DIR, OD, RISE_EN, FALL_EN, IRQ_STATUS, the sync flops, the write pipeline and the read response. After reset: all pins Z, irq=0, rd_ready=0, rd_data=0.
- Hit: addr[11:6] == (BASE+OFFSET)[11:6]. Byte offset is addr[5:0].
- Write map:
  - 0x00/0x04 DIR clr/set
  - 0x08/0x0C OD clr/set
  - 0x10/0x14 OUT clr/set
  - 0x18 RISE_EN load
  - 0x1C FALL_EN load
  - 0x24 IRQ_STATUS write-1-to-clear
  - Other offsets are ignored. Clr: reg &= ~data. Set: reg |= data.
- Write latency: wr_valid in cycle N. Address and data are registered at the end of N; the target register updates at the end of N+1. The new value is visible on pins and reads from N+2. Back-to-back writes every cycle are supported and applied in order.
- Read map:
  - 0x20 DATA_IN (sync stage 2)
  - 0x24 IRQ_STATUS
  - 0x28 OUT
  - 0x2C DIR
  - 0x30 OD
  - 0x34 RISE_EN
  - 0x38 FALL_EN
  - Other in-window offsets return 0.
- Read latency: rd_valid in cycle N with a hit gives rd_ready=1 and data in cycle N+1, both registered. A miss gives no response. A read returns the register value at the end of N, i.e. before any same-edge update.
- Pin drive, per bit:
  - DIR=0: Z.
  - DIR=1 and OD=0: drive OUT.
  - DIR=1 and OD=1: OUT=0 drives 0, OUT=1 gives Z.
- Input path: s1<=pin, s2<=s1, s3<=s2.
  - rise = s2 & ~s3 & RISE_EN; fall = ~s2 & s3 & FALL_EN.
  - IRQ_STATUS bit sets on the 3rd rising clk edge after the pin change; irq follows combinationally.
  - X/Z on a pin is resolved to 0 before s1.
- Simultaneous W1C and a new edge on the same bit: set wins, bit stays 1. Other bits clear normally.
- Both RISE_EN and FALL_EN set: either edge sets status.
- Enabling RISE_EN while a pin is already high does not set status; only transitions seen after enable count.
- Reset mid-write: a pending pipelined write is discarded.
- Pins driven by the block itself are also sampled, so a self-toggle raises status when enabled.

Decomposition:
- Package gpio_pkg: ADDR_W=12; WIN_LSB=6; localparams for every register offset (DIR_CLR..FALL_EN, DATA_IN, IRQ_STATUS, OUT_RD, DIR_RD, OD_RD, RISE_RD, FALL_RD).
- Sub-module gpio_in_sync (GPIO_BW wide): 3 flops with synchronous active-low reset; outputs s2, rise_raw, fall_raw. Top applies the enables.

Test Plan:
- Reset, then write 0x04=0xF and 0x14=0x5 -> from cycle N+2 pins read 0101 driven; reads of 0x28 and 0x2C return 0x5 and 0xF with rd_ready one cycle after rd_valid.
- OD=0x3 (0x0C), OUT=0x1, DIR=0x3 -> pin0 Z, pin1 driven 0; clear OUT (0x10=0x1) -> pin0 driven 0 at N+2.
- RISE_EN=0x2; drive pin1 0->1 externally -> IRQ_STATUS=0x2 and irq=1 at the 3rd edge; write 0x24=0x2 -> irq=0 at N+2.
- W1C of bit0 in the same cycle status bit0 would set from a fall edge (FALL_EN=0x1) -> bit0 stays 1, irq stays 1.
- Read 0x3C (in window) -> rd_ready=1, data 0. Read BASE+0x40 -> no rd_ready.
- Assert rst_n=0 one cycle after a 0x14 write -> OUT stays 0, pins Z, irq=0.
